sprite_motion_ctrl: RTL and testbench
=====================================

Name: sprite_motion_ctrl

Overview:
- Per-sprite motion and animation sequencer. Drives the x_init/y_init position inputs and the animation frame base of one sprite item instance.
- Once per video frame, on a pulse issued during vertical blanking, it steps position by a signed velocity, bounces at screen edges and advances the animation frame.
- Game logic loads position/velocity through a valid/ready command port.

Parameters:
SCR_W, 640, active screen width in pixels
SCR_H, 480, active screen height in pixels
SPR_W, 64, on-screen sprite width (already scaled)
SPR_H, 64, on-screen sprite height (already scaled)
FRAMES, 4, animation frames stored in sprite ROM
PIXELS, 4096, ROM words per animation frame
ANIM_DIV, 8, video frames per animation step (>=1)
VELW, 8, signed velocity width

Ports:
i_clk_25  in  1  pixel clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_frame  in  1  one-cycle pulse, once per video frame during vblank
i_enable  in  1  motion/animation enable
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command ready
i_cmd_x  in  20  new x position
i_cmd_y  in  20  new y position
i_cmd_vx  in  VELW  new signed x velocity
i_cmd_vy  in  VELW  new signed y velocity
o_x_pos  out  20  sprite x, feeds x_init
o_y_pos  out  20  sprite y, feeds y_init
o_anim  out  clog2(FRAMES)  current animation frame
o_frame_base  out  clog2(FRAMES*PIXELS)  o_anim*PIXELS, ROM address offset
o_hit_x  out  1  one-cycle pulse on x edge contact
o_hit_y  out  1  one-cycle pulse on y edge contact
o_busy  out  1  high in STEP_X/STEP_Y

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all position, velocity, animation and frame-base registers 0; hit pulses 0; o_busy 0.
- Bounds: XMAX = SCR_W-SPR_W (576), YMAX = SCR_H-SPR_H (416). All arithmetic is 21-bit signed; velocity is sign-extended.
- States:
  - IDLE: entered when i_enable=0; i_frame ignored; outputs held.
  - RUN: if i_enable=0, go to IDLE. On i_frame, go to STEP_X.
  - STEP_X: compute nx = x+vx into a shadow register; go to STEP_Y.
  - STEP_Y: compute ny = y+vy; commit both shadows to o_x_pos/o_y_pos in the same edge; update the animation counter; go to RUN, or IDLE if i_enable=0.
- Latency: i_frame sampled at edge t; o_x_pos, o_y_pos and o_anim change together at edge t+2. No position tearing.
- Bounce, per axis:
  - n<0: pos=0, velocity negated, hit pulse.
  - n>MAX: pos=MAX, velocity negated, hit pulse.
  - n==0 or n==MAX: pos=n, no negation, no pulse.
  - Hit pulses assert exactly at the commit edge, for one cycle.
- Animation: a frame counter increments at each commit. When it reaches ANIM_DIV-1 it clears and o_anim increments, wrapping FRAMES-1 -> 0. o_frame_base is registered in the same edge as o_anim.
- Command port:
  - o_cmd_ready=1 in IDLE and RUN, 0 in STEP states.
  - On valid&&ready: position is loaded clamped to [0,MAX]; velocity loaded; anim and frame counter cleared. Outputs visible on the next edge; no hit pulse.
  - Accepted in IDLE, the state stays IDLE.
- Simultaneous i_frame and accepted command in RUN: the command wins and that frame step is skipped.
- i_frame during STEP states: ignored.
- i_enable dropping mid-step: the step completes, then IDLE.
- Reset mid-step: shadows discarded, outputs return to 0.

Optional Feature:
SPRITE_WRAP_EN
- Defined:
  - n<0 -> pos = n+XMAX+1.
  - n>MAX -> pos = n-(XMAX+1).
  - Same rules for y with YMAX.
  - Velocity is never negated; hit pulses still fire on each wrap.
  - Required constraint: |v| <= MAX.
- Undefined: bounce behaviour above.

Test Plan:
- Reset with i_enable=1 and pulses running -> all outputs 0, o_cmd_ready=1 on the first cycle after release.
- Command x=570 y=100 vx=+10 vy=-3, then i_frame -> at t+2: x=576, y=97, o_hit_x pulse for 1 cycle. Next i_frame -> x=566 (vx=-10).
- Command x=2 vx=-5 -> x=0, hit_x. Command x=0 vx=0 -> x stays 0, no hit. Command x=900 -> loaded as 576.
- ANIM_DIV=8, FRAMES=4, 32 i_frame pulses -> o_anim sequence 0,1,2,3,0 changing every 8th commit; o_frame_base = 4096*o_anim.
- i_frame and accepted command in the same cycle -> command values appear with no step applied. i_frame while o_busy=1 -> no extra step. Deassert i_enable during STEP_X -> commit occurs, then IDLE ignores further pulses.
- SPRITE_WRAP_EN, x=570 vx=+10 -> x=3, vx stays +10, o_hit_x pulses.

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// Per-sprite motion and animation sequencer.
// Once per video frame it steps the sprite position by a signed velocity, handles
// screen-edge contact and advances the animation frame. Game logic reloads
// position/velocity through a valid/ready command port.
// Optional build macro: SPRITE_WRAP_EN (wrap around screen edges instead of bouncing).
// FRAMES must be >= 2 so that o_anim has at least one bit.
module sprite_motion_ctrl #(
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 64,
    parameter int FRAMES   = 4,
    parameter int PIXELS   = 4096,
    parameter int ANIM_DIV = 8,
    parameter int VELW     = 8
) (
    input  logic                                i_clk_25,
    input  logic                                i_rst_n,
    input  logic                                i_frame,
    input  logic                                i_enable,
    input  logic                                i_cmd_valid,
    output logic                                o_cmd_ready,
    input  logic [19:0]                         i_cmd_x,
    input  logic [19:0]                         i_cmd_y,
    input  logic [VELW-1:0]                     i_cmd_vx,
    input  logic [VELW-1:0]                     i_cmd_vy,
    output logic [19:0]                         o_x_pos,
    output logic [19:0]                         o_y_pos,
    output logic [$clog2(FRAMES)-1:0]           o_anim,
    output logic [$clog2(FRAMES*PIXELS)-1:0]    o_frame_base,
    output logic                                o_hit_x,
    output logic                                o_hit_y,
    output logic                                o_busy
);

    localparam int AW   = $clog2(FRAMES);
    localparam int FBW  = $clog2(FRAMES * PIXELS);
    localparam int CW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int XMAX = SCR_W - SPR_W;
    localparam int YMAX = SCR_H - SPR_H;

    localparam logic signed [20:0] XMAX_S = 21'(XMAX);
    localparam logic signed [20:0] YMAX_S = 21'(YMAX);
    localparam logic [19:0]        XMAX_U = 20'(XMAX);
    localparam logic [19:0]        YMAX_U = 20'(YMAX);

    typedef enum logic [1:0] {StIdle, StRun, StStepX, StStepY} state_t;

    state_t                  r_state;
    state_t                  w_state_d;
    logic [19:0]             r_x;
    logic [19:0]             r_y;
    logic signed [VELW-1:0]  r_vx;
    logic signed [VELW-1:0]  r_vy;
    logic signed [20:0]      r_nx;      // x shadow, committed together with y
    logic [AW-1:0]           r_anim;
    logic [FBW-1:0]          r_fbase;
    logic [CW-1:0]           r_fcnt;
    logic                    r_hit_x;
    logic                    r_hit_y;

    logic                    w_cmd_acc;
    logic signed [20:0]      w_nx;
    logic signed [20:0]      w_ny;
    logic                    w_hit_x;
    logic                    w_hit_y;
    logic [19:0]             w_cmd_x;
    logic [19:0]             w_cmd_y;
    logic [AW-1:0]           w_anim_nx;

    function automatic logic signed [20:0] f_sext(input logic signed [VELW-1:0] v);
        return {{(21 - VELW){v[VELW-1]}}, v};
    endfunction

    // Edge contact: candidate left the [0, mx] range.
    function automatic logic f_out(input logic signed [20:0] n, input logic signed [20:0] mx);
        return (n < 21'sd0) || (n > mx);
    endfunction

    // Final on-screen position for a candidate coordinate.
    function automatic logic [19:0] f_resolve(input logic signed [20:0] n,
                                              input logic signed [20:0] mx);
        logic signed [20:0] r;
        r = n;
`ifdef SPRITE_WRAP_EN
        if (n < 21'sd0) begin
            r = n + mx + 21'sd1;
        end else if (n > mx) begin
            r = n - (mx + 21'sd1);
        end
`else
        if (n < 21'sd0) begin
            r = 21'sd0;
        end else if (n > mx) begin
            r = mx;
        end
`endif
        return r[19:0];
    endfunction

    // Command handshake, candidate positions, edge detection and clamped load values.
    always_comb begin
        o_cmd_ready = (r_state == StIdle) || (r_state == StRun);
        w_cmd_acc   = i_cmd_valid && o_cmd_ready;
        w_nx        = $signed({1'b0, r_x}) + f_sext(r_vx);
        w_ny        = $signed({1'b0, r_y}) + f_sext(r_vy);
        w_hit_x     = f_out(r_nx, XMAX_S);
        w_hit_y     = f_out(w_ny, YMAX_S);
        w_cmd_x     = (i_cmd_x > XMAX_U) ? XMAX_U : i_cmd_x;
        w_cmd_y     = (i_cmd_y > YMAX_U) ? YMAX_U : i_cmd_y;
        w_anim_nx   = (r_anim == AW'(FRAMES - 1)) ? '0 : r_anim + 1'b1;
    end

    // Next-state logic; an accepted command pre-empts a frame step.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_enable && !w_cmd_acc) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (!i_enable) begin
                    w_state_d = StIdle;
                end else if (i_frame && !w_cmd_acc) begin
                    w_state_d = StStepX;
                end
            end
            StStepX: w_state_d = StStepY;
            StStepY: w_state_d = i_enable ? StRun : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Position, velocity, animation and hit-pulse registers.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_vx    <= '0;
            r_vy    <= '0;
            r_nx    <= '0;
            r_anim  <= '0;
            r_fbase <= '0;
            r_fcnt  <= '0;
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
        end else begin
            r_hit_x <= 1'b0;
            r_hit_y <= 1'b0;
            if (w_cmd_acc) begin
                r_x     <= w_cmd_x;
                r_y     <= w_cmd_y;
                r_vx    <= i_cmd_vx;
                r_vy    <= i_cmd_vy;
                r_anim  <= '0;
                r_fbase <= '0;
                r_fcnt  <= '0;
            end else if (r_state == StStepX) begin
                r_nx <= w_nx;
            end else if (r_state == StStepY) begin
                r_x     <= f_resolve(r_nx, XMAX_S);
                r_y     <= f_resolve(w_ny, YMAX_S);
                r_hit_x <= w_hit_x;
                r_hit_y <= w_hit_y;
`ifndef SPRITE_WRAP_EN
                if (w_hit_x) begin
                    r_vx <= -r_vx;
                end
                if (w_hit_y) begin
                    r_vy <= -r_vy;
                end
`endif
                if (r_fcnt == CW'(ANIM_DIV - 1)) begin
                    r_fcnt  <= '0;
                    r_anim  <= w_anim_nx;
                    r_fbase <= FBW'(w_anim_nx) * FBW'(PIXELS);
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    // Output mapping.
    always_comb begin
        o_x_pos      = r_x;
        o_y_pos      = r_y;
        o_anim       = r_anim;
        o_frame_base = r_fbase;
        o_hit_x      = r_hit_x;
        o_hit_y      = r_hit_y;
        o_busy       = (r_state == StStepX) || (r_state == StStepY);
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl (default parameters).
// Expected observations come from a small behavioural model and are queued when
// stimulus is driven, then popped and compared once the DUT shows its result.
module tb_sprite_motion_ctrl;

    localparam int XMAX     = 576;
    localparam int YMAX     = 416;
    localparam int ANIM_DIV = 8;
    localparam int FRAMES   = 4;
    localparam int PIXELS   = 4096;

    typedef struct packed {
        logic [19:0] x;
        logic [19:0] y;
        logic [1:0]  anim;
        logic [13:0] fb;
        logic        hx;
        logic        hy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_x;
    logic [19:0] cmd_y;
    logic [7:0]  cmd_vx;
    logic [7:0]  cmd_vy;
    logic [19:0] x_pos;
    logic [19:0] y_pos;
    logic [1:0]  anim;
    logic [13:0] fbase;
    logic        hit_x;
    logic        hit_y;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    int mx, my, mvx, mvy, manim, mfcnt;

    always #20 clk = ~clk;

    sprite_motion_ctrl dut (
        .i_clk_25     (clk),
        .i_rst_n      (rst_n),
        .i_frame      (frame),
        .i_enable     (enable),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_x      (cmd_x),
        .i_cmd_y      (cmd_y),
        .i_cmd_vx     (cmd_vx),
        .i_cmd_vy     (cmd_vy),
        .o_x_pos      (x_pos),
        .o_y_pos      (y_pos),
        .o_anim       (anim),
        .o_frame_base (fbase),
        .o_hit_x      (hit_x),
        .o_hit_y      (hit_y),
        .o_busy       (busy)
    );

    function automatic obs_t sample();
        return {x_pos, y_pos, anim, fbase, hit_x, hit_y};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d anim=%0d base=%0d hx=%0b hy=%0b",
                         o.x, o.y, o.anim, o.fb, o.hx, o.hy);
    endfunction

    function automatic obs_t model_obs(input logic hx, input logic hy);
        obs_t o;
        o.x    = 20'(mx);
        o.y    = 20'(my);
        o.anim = 2'(manim);
        o.fb   = 14'(manim * PIXELS);
        o.hx   = hx;
        o.hy   = hy;
        return o;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mvx = 0; mvy = 0; manim = 0; mfcnt = 0;
    endtask

    task automatic model_axis(inout int p, inout int v, input int lim, output logic hit);
        int n;
        n   = p + v;
        hit = 1'b0;
`ifdef SPRITE_WRAP_EN
        if (n < 0) begin
            p = n + lim + 1; hit = 1'b1;
        end else if (n > lim) begin
            p = n - lim - 1; hit = 1'b1;
        end else begin
            p = n;
        end
`else
        if (n < 0) begin
            p = 0; v = -v; hit = 1'b1;
        end else if (n > lim) begin
            p = lim; v = -v; hit = 1'b1;
        end else begin
            p = n;
        end
`endif
    endtask

    task automatic model_step(output obs_t e);
        logic hx, hy;
        model_axis(mx, mvx, XMAX, hx);
        model_axis(my, mvy, YMAX, hy);
        if (mfcnt == ANIM_DIV - 1) begin
            mfcnt = 0;
            manim = (manim + 1) % FRAMES;
        end else begin
            mfcnt = mfcnt + 1;
        end
        e = model_obs(hx, hy);
    endtask

    task automatic model_cmd(input int x, input int y, input int vx, input int vy,
                             output obs_t e);
        mx = (x > XMAX) ? XMAX : x;
        my = (y > YMAX) ? YMAX : y;
        mvx = vx; mvy = vy; manim = 0; mfcnt = 0;
        e = model_obs(1'b0, 1'b0);
    endtask

    // Called at a falling edge; returns one falling edge later with the load visible.
    task automatic drive_cmd(input int x, input int y, input int vx, input int vy);
        obs_t e;
        cmd_valid = 1'b1;
        cmd_x     = 20'(x);
        cmd_y     = 20'(y);
        cmd_vx    = 8'(vx);
        cmd_vy    = 8'(vy);
        model_cmd(x, y, vx, vy, e);
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge right after the commit.
    task automatic drive_frame();
        obs_t e;
        frame = 1'b1;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t g;
        rst_n = 1'b0; enable = 1'b1; frame = 1'b0; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_vx = '0; cmd_vy = '0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            frame = ~frame;
        end
        g = sample();
        checks++;
        if (g !== obs_t'(0)) begin
            errors++; $display("FAIL reset_outputs: got %s, expected all zero", fmt(g));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        @(negedge clk);
        frame = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, expected 1", cmd_ready);
        end
    endtask

    task automatic test_bounce();
        obs_t e, g, prev;
        @(negedge clk);
        drive_cmd(570, 100, 10, -3);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL bounce_load: got %s, expected %s", fmt(g), fmt(e));
        end
        prev  = e;
        frame = 1'b1;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        frame = 1'b0;
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL step_flags: got busy=%b ready=%b, expected busy=1 ready=0",
                     busy, cmd_ready);
        end
        @(negedge clk);
        g = sample(); checks++;
        if (g !== prev) begin
            errors++; $display("FAIL no_tearing: got %s, expected %s", fmt(g), fmt(prev));
        end
        @(negedge clk);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL bounce_commit: got %s, expected %s", fmt(g), fmt(e));
        end
        @(negedge clk);
        checks++;
        if ({hit_x, hit_y} !== 2'b00) begin
            errors++; $display("FAIL hit_one_cycle: got hx=%b hy=%b, expected 0 0", hit_x, hit_y);
        end
        drive_frame();
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL bounce_reverse: got %s, expected %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_edges();
        obs_t e, g;
        int xs[3]  = '{2, 0, 900};
        int ys[3]  = '{50, 50, 410};
        int vxs[3] = '{-5, 0, 0};
        int vys[3] = '{0, 0, 6};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive_cmd(xs[i], ys[i], vxs[i], vys[i]);
            e = sb.pop_front(); g = sample(); checks++;
            if (g !== e) begin
                errors++; $display("FAIL edge_load_%0d: got %s, expected %s", i, fmt(g), fmt(e));
            end
            drive_frame();
            e = sb.pop_front(); g = sample(); checks++;
            if (g !== e) begin
                errors++; $display("FAIL edge_step_%0d: got %s, expected %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_anim();
        obs_t e, g;
        @(negedge clk);
        drive_cmd(100, 100, 0, 0);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL anim_load: got %s, expected %s", fmt(g), fmt(e));
        end
        for (int i = 0; i < 32; i++) begin
            drive_frame();
            e = sb.pop_front(); g = sample(); checks++;
            if (g !== e) begin
                errors++; $display("FAIL anim_step_%0d: got %s, expected %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_cmd_wins();
        obs_t e, g;
        @(negedge clk);
        frame = 1'b1;
        drive_cmd(200, 200, 7, 7);
        frame = 1'b0;
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL cmd_wins_load: got %s, expected %s", fmt(g), fmt(e));
        end
        repeat (3) @(negedge clk);
        g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL cmd_wins_no_step: got %s, expected %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        @(negedge clk);
        frame = 1'b1;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        frame = 1'b0;
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL busy_commit: got %s, expected %s", fmt(g), fmt(e));
        end
        e = model_obs(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL busy_no_extra: got %s, expected %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_enable_drop();
        obs_t e, g;
        @(negedge clk);
        frame = 1'b1;
        model_step(e);
        sb.push_back(e);
        @(negedge clk);
        frame  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL enable_drop_commit: got %s, expected %s", fmt(g), fmt(e));
        end
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (3) @(negedge clk);
        e = model_obs(1'b0, 1'b0); g = sample(); checks++;
        if (g !== e || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_frame: got %s busy=%b, expected %s busy=0",
                     fmt(g), busy, fmt(e));
        end
        drive_cmd(50, 60, 3, 4);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL idle_cmd_load: got %s, expected %s", fmt(g), fmt(e));
        end
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (3) @(negedge clk);
        g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL idle_after_cmd: got %s, expected %s", fmt(g), fmt(e));
        end
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_step();
        obs_t e, g;
        @(negedge clk);
        drive_cmd(300, 200, 5, 5);
        e = sb.pop_front(); g = sample(); checks++;
        if (g !== e) begin
            errors++; $display("FAIL mid_reset_load: got %s, expected %s", fmt(g), fmt(e));
        end
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        g = sample(); checks++;
        if (g !== obs_t'(0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got %s busy=%b, expected zero busy=0", fmt(g), busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        g = sample(); checks++;
        if (g !== obs_t'(0)) begin
            errors++; $display("FAIL shadow_discarded: got %s, expected all zero", fmt(g));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounce();
        test_edges();
        test_anim();
        test_cmd_wins();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
